// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int ITER = 32;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate, used for magnitudes and sign fix.
module muldiv_abs #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Define FAST_MUL_EN to replace the shift-add multiply with a native one.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] mt_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t               state;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     md;
   logic [CNT_W-1:0]     cnt;
   logic                 neg_q;
   logic                 neg_r;
   logic                 is_div;

   logic                 sgn_op;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   p_fix;
   logic [WIDTH-1:0]     q_fix;
   logic [WIDTH-1:0]     r_fix;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_r;
   logic [WIDTH:0]       div_d;
   logic [2*WIDTH-1:0]   div_next;

   assign sgn_op = ~op[0];

   muldiv_abs #(.W(WIDTH)) u_abs_a (
      .neg (sgn_op & a[WIDTH-1]),
      .x   (a),
      .y   (a_mag)
   );

   muldiv_abs #(.W(WIDTH)) u_abs_b (
      .neg (sgn_op & b[WIDTH-1]),
      .x   (b),
      .y   (b_mag)
   );

   muldiv_abs #(.W(2*WIDTH)) u_fix_p (
      .neg (neg_q),
      .x   (acc),
      .y   (p_fix)
   );

   muldiv_abs #(.W(WIDTH)) u_fix_q (
      .neg (neg_q),
      .x   (acc[WIDTH-1:0]),
      .y   (q_fix)
   );

   muldiv_abs #(.W(WIDTH)) u_fix_r (
      .neg (neg_r),
      .x   (acc[2*WIDTH-1:WIDTH]),
      .y   (r_fix)
   );

   // Shift-add: multiplier in acc low half, partial product grows from the top.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, md};
   assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                            : {1'b0, acc[2*WIDTH-1:1]};

   // Restoring divide: remainder in acc high half, quotient shifts in low.
   assign div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_d    = div_r - {1'b0, md};
   assign div_next = div_d[WIDTH]
                   ? {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_p;
   assign fast_p = a_mag * b_mag;
`endif

   always_ff @(posedge CLK or posedge RST_n) begin
      if (RST_n) begin
         state    <= IDLE;
         acc      <= '0;
         md       <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_div   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (start && !flush) begin
                  neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= sgn_op & a[WIDTH-1];
                  is_div <= op[1];
                  cnt    <= '0;
                  md     <= b_mag;
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  if (op[1] && b == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                     hi       <= a;
                     lo       <= '1;
                  end else if (op[1]) begin
                     state <= DIV;
                     busy  <= 1'b1;
                  end else begin
`ifdef FAST_MUL_EN
                     acc   <= fast_p;
                     state <= FIX;
`else
                     state <= MUL;
`endif
                     busy  <= 1'b1;
                  end
               end else begin
                  if (hi_we) hi <= mt_data;
                  if (lo_we) lo <= mt_data;
               end
            end
            MUL, DIV: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= (state == MUL) ? mul_next : div_next;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(ITER - 1)) state <= FIX;
               end
            end
            FIX: begin
               state <= flush ? IDLE : DONE;
               busy  <= 1'b0;
               if (!flush) begin
                  done <= 1'b1;
                  if (is_div) begin
                     hi <= r_fix;
                     lo <= q_fix;
                  end else begin
                     {hi, lo} <= p_fix;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (both FAST_MUL_EN builds).
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] mt_data = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk = 0;
   int n_fail = 0;

`ifdef FAST_MUL_EN
   localparam int MUL_LAT = 2;
   localparam int MUL_BSY = 1;
`else
   localparam int MUL_LAT = 34;
   localparam int MUL_BSY = 33;
`endif

   always #5 CLK = ~CLK;

   muldiv_unit dut (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .flush    (flush),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .mt_data  (mt_data),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   // Launch one op and follow it to done; lat counts cycles after T.
   task automatic do_op(input logic [1:0] o,
                        input logic [31:0] x, y,
                        output int lat, output int bcnt,
                        output bit dn, output bit dz);
      @(negedge CLK);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge CLK);
      #1 start = 1'b0;
      lat = 0; bcnt = 0; dn = 1'b0; dz = 1'b0;
      for (int k = 1; k <= 60 && !dn; k++) begin
         @(negedge CLK);
         if (done) begin
            dn = 1'b1; lat = k; dz = div_zero;
         end else if (busy) begin
            bcnt++;
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      n_chk++;
      if ({busy, done, div_zero} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000",
                  {busy, done, div_zero});
      end
      n_chk++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_hilo got %h want 0", {hi, lo});
      end
   endtask

   task automatic test_multu;
      int lat, bc; bit dn, dz;
      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dn, dz);
      n_chk++;
      if (!dn || lat !== MUL_LAT) begin
         n_fail++;
         $display("FAIL multu_lat got %0d want %0d", lat, MUL_LAT);
      end
      n_chk++;
      if (bc !== MUL_BSY) begin
         n_fail++;
         $display("FAIL multu_busy got %0d want %0d", bc, MUL_BSY);
      end
      n_chk++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++;
         $display("FAIL multu_res got %h want fffffffe00000001",
                  {hi, lo});
      end
   endtask

   task automatic test_mult;
      int lat, bc; bit dn, dz;
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc, dn, dz);
      n_chk++;
      if (!dn || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         n_fail++;
         $display("FAIL mult_neg got %h want fffffffffffffff1",
                  {hi, lo});
      end
      do_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, lat, bc, dn, dz);
      n_chk++;
      if (!dn || lat !== MUL_LAT || {hi, lo} !== 64'h1_0000_0000) begin
         n_fail++;
         $display("FAIL mult_big got %h lat %0d want 100000000 lat %0d",
                  {hi, lo}, lat, MUL_LAT);
      end
   endtask

   task automatic test_div;
      int lat, bc; bit dn, dz;
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, dn, dz);
      n_chk++;
      if (!dn || lat !== 34 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_neg got %h lat %0d want ffffffff fffffffd",
                  {hi, lo}, lat);
      end
      do_op(OP_DIVU, 32'd100, 32'd7, lat, bc, dn, dz);
      n_chk++;
      if (!dn || {hi, lo} !== {32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL divu got %h want 2/14", {hi, lo});
      end
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dn, dz);
      n_chk++;
      if (!dn || {hi, lo} !== 64'h0000_0000_8000_0000) begin
         n_fail++;
         $display("FAIL div_ovf got %h want 0000000080000000", {hi, lo});
      end
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc, dn, dz);
      n_chk++;
      if (!dn || {hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_negb got %h want 00000001fffffffd",
                  {hi, lo});
      end
   endtask

   task automatic test_div_zero;
      int lat, bc; bit dn, dz;
      do_op(OP_DIV, 32'h1234, 32'd0, lat, bc, dn, dz);
      n_chk++;
      if (!dn || lat !== 1 || dz !== 1'b1) begin
         n_fail++;
         $display("FAIL dz_flag got lat %0d dz %b want 1 1", lat, dz);
      end
      n_chk++;
      if (bc !== 0) begin
         n_fail++;
         $display("FAIL dz_busy got %0d want 0", bc);
      end
      n_chk++;
      if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL dz_res got %h want 00001234ffffffff", {hi, lo});
      end
   endtask

   task automatic test_flush;
      bit seen = 1'b0;
      @(negedge CLK);
      hi_we = 1'b1; mt_data = 32'hAAAA;
      @(negedge CLK);
      hi_we = 1'b0;
      n_chk++;
      if (hi !== 32'hAAAA) begin
         n_fail++;
         $display("FAIL mthi got %h want 0000aaaa", hi);
      end
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
      @(negedge CLK);
      start = 1'b0;
      repeat (9) @(negedge CLK);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle got busy %b done %b want 0 0",
                  busy, done);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (done || busy) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0 || hi !== 32'hAAAA) begin
         n_fail++;
         $display("FAIL flush_quiet got act %b hi %h want 0 0000aaaa",
                  seen, hi);
      end
   endtask

   task automatic test_back_to_back;
      bit dn = 1'b0;
      int lat = 0;
      @(negedge CLK);
      start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
      @(negedge CLK);
      start = 1'b0;
      for (int k = 6; k <= 60 && !dn; k++) begin
         if (done) begin dn = 1'b1; lat = k; end
         else @(negedge CLK);
      end
      n_chk++;
      if (!dn || {hi, lo} !== 64'd42) begin
         n_fail++;
         $display("FAIL b2b_res got %h want 42", {hi, lo});
      end
   endtask

   task automatic test_mt;
      int lat, bc; bit dn, dz;
      dn = 1'b0;
      @(negedge CLK);
      start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
      @(negedge CLK);
      start = 1'b0;
      @(negedge CLK);
      lo_we = 1'b1; mt_data = 32'h55;
      @(negedge CLK);
      lo_we = 1'b0;
      for (int k = 0; k < 60 && !dn; k++) begin
         if (done) dn = 1'b1;
         else @(negedge CLK);
      end
      n_chk++;
      if (!dn || {hi, lo} !== 64'd12) begin
         n_fail++;
         $display("FAIL mt_busy got %h want 12", {hi, lo});
      end
      @(negedge CLK);
      lo_we = 1'b1; mt_data = 32'h55;
      @(negedge CLK);
      lo_we = 1'b0;
      n_chk++;
      if (lo !== 32'h55) begin
         n_fail++;
         $display("FAIL mtlo got %h want 00000055", lo);
      end
      @(negedge CLK);
      hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h77;
      start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd2;
      @(posedge CLK);
      #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      dn = 1'b0;
      for (int k = 0; k < 60 && !dn; k++) begin
         @(negedge CLK);
         if (done) dn = 1'b1;
      end
      n_chk++;
      if (!dn || {hi, lo} !== {32'd1, 32'd4}) begin
         n_fail++;
         $display("FAIL mt_start got %h want 1/4", {hi, lo});
      end
      @(negedge CLK);
      hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h99;
      @(negedge CLK);
      hi_we = 1'b0; lo_we = 1'b0;
      n_chk++;
      if ({hi, lo} !== {32'h99, 32'h99}) begin
         n_fail++;
         $display("FAIL mt_both got %h want 99/99", {hi, lo});
      end
   endtask

   task automatic test_reset_midop;
      @(negedge CLK);
      start = 1'b1; op = OP_MULT; a = 32'd11; b = 32'd13;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (19) @(posedge CLK);
      #2 RST_n = 1'b1;
      #1;
      n_chk++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_fail++;
         $display("FAIL rst_mid got b%b d%b %h want 0",
                  busy, done, {hi, lo});
      end
      @(negedge CLK);
      RST_n = 1'b0;
      repeat (40) @(negedge CLK);
      n_chk++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_fail++;
         $display("FAIL rst_after got b%b d%b %h want 0",
                  busy, done, {hi, lo});
      end
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      test_reset;
      RST_n = 1'b0;
      @(negedge CLK);
      test_reset;
      test_multu;
      test_mult;
      test_div;
      test_div_zero;
      test_flush;
      test_back_to_back;
      test_mt;
      test_reset_midop;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS core, with its own HI/LO registers. It sits upstream of the general-purpose register file. MFHI/MFLO results are muxed onto the register-file write-data path, and MTHI/MTLO arrive from the same datapath. It executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake and a pipeline flush.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_n  in  1  reset, asynchronous, active-high
start  in  1  launch operation; sampled only in IDLE or DONE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand / dividend
b  in  WIDTH  rt operand / divisor
flush  in  1  abort in-flight operation
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
mt_data  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse
div_zero  out  1  qualifies done: divide by zero
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (RST_n=1, async, any state): state=IDLE; hi=lo=0; busy=done=div_zero=0; counter and accumulators cleared.
- States and transitions:
  - IDLE: start → MUL (op[1]=0) or DIV (op[1]=1). DIV with b=0 goes straight to DONE.
  - MUL / DIV: 32 iterations, counter 0..31 → FIX.
  - FIX: one cycle → DONE.
  - DONE: one cycle; start behaves as in IDLE, otherwise → IDLE.
- Capture at start: a, b and op are registered on the start edge. Signed ops take the magnitudes |a| and |b| and record the result signs.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator.
- DIV: one restoring step per cycle; quotient → lo, remainder → hi.
- FIX: signed ops negate where needed.
  - Product sign = a[31]^b[31].
  - Quotient sign = a[31]^b[31]; remainder sign = a[31].
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
  - hi/lo are written on the edge leaving FIX.
- Latency: start at cycle T.
  - busy=1 in cycles T+1..T+33.
  - done=1 and busy=0 in T+34; hi/lo hold the new result in T+34.
- Divide by zero: DONE at T+1, done=div_zero=1, hi=a, lo=0xFFFFFFFF; busy never asserts.
- start while busy: ignored, no effect.
- flush: in MUL/DIV/FIX → IDLE on the next edge; hi/lo unchanged, no done. In IDLE/DONE: no effect, and an accompanying start is also dropped.
- MTHI/MTLO:
  - Applied only in IDLE or DONE; ignored while busy.
  - A start in the same cycle takes priority and the move is discarded.
  - hi_we and lo_we together write both registers.
- hi/lo are stable outputs whenever busy=0; the register-file write port consumes them combinationally.

Optional Feature:
FAST_MUL_EN
- Defined: MUL state bypassed. Full product computed in one cycle with a native multiplier. Start at T → FIX at T+1 → done at T+2. Divide path unchanged.
- Undefined: iterative 34-cycle multiply as above, no multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MULT=2'b00, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, MUL, DIV, FIX, DONE);
  - the ITER constant = 32.
- One sub-module, muldiv_abs: combinational conditional two's-complement negate. It is used for operand magnitudes on entry and for result sign fix in FIX.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done at T+34; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIV a=0x1234 b=0 → done=div_zero=1 at T+1; hi=0x1234, lo=0xFFFFFFFF; busy never high.
- After MTHI 0xAAAA, start DIVU, assert flush at T+10 → IDLE at T+11, no done, hi=0xAAAA. A second start 5 cycles into an op is ignored and the first result is correct.
- RST_n pulse at T+20 of a MULT → hi=lo=0, busy=done=0 immediately. MTLO 0x55 while busy is ignored; MTLO in IDLE → lo=0x55 next cycle.
- With FAST_MUL_EN: MULT 0x10000*0x10000 → done at T+2, hi=0x1, lo=0x0.
